// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types and defaults for the SDRAM port arbiter
// Purpose: FSM state encoding, default bus widths and the timeout limit.
// Ports: none (package).
package sdram_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam int DEF_ADDR_W  = 23;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 255;
  localparam int CNT_W       = 8;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin request picker
// Purpose: selects the first requester scanning last+1, last+2, ... modulo NUM_REQ,
//          so the previous winner has the lowest priority.
// Ports:
//   req    in  NUM_REQ  request vector
//   last   in  IDX_W    index of the previous winner
//   onehot out NUM_REQ  one-hot selected requester (0 when none)
//   index  out IDX_W    binary index of the selected requester
//   valid  out 1        at least one request present
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   index,
  output logic               valid
);

  always_comb begin
    logic [IDX_W-1:0] cand;
    onehot = '0;
    index  = '0;
    valid  = 1'b0;
    cand   = '0;
    // i runs 1..NUM_REQ so the previous winner is examined last.
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(last) + i) % NUM_REQ);
      if (!valid && req[cand]) begin
        valid        = 1'b1;
        onehot[cand] = 1'b1;
        index        = cand;
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - round-robin arbiter sharing one SDRAM port between NUM_REQ masters
// Purpose: grants one access per grant, latches the winning command for the whole access,
//          routes completion/readdata back to the owner, forces completion on timeout.
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-low reset
//   req_read/req_write           per-master level requests, held until finished
//   req_addr/req_writedata       packed per-master command fields
//   req_readdata/req_finished    completion data and pulse to the granted master
//   sdram_*                      command/completion interface to the SDRAM controller
//   grant, busy                  current owner (one-hot) and access-in-progress flag
//   timeout_err, clr_err         sticky error flag and its synchronous clear
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NUM_REQ-1:0]    req_read,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_writedata,
  output logic [DATA_W-1:0]     req_readdata,
  output logic [NUM_REQ-1:0]    req_finished,
  output logic                  sdram_read,
  output logic                  sdram_write,
  output logic [ADDR_W-1:0]     sdram_addr,
  output logic [DATA_W-1:0]     sdram_writedata,
  input  logic [DATA_W-1:0]     sdram_readdata,
  input  logic                  sdram_finished,
  output logic [NUM_REQ-1:0]    grant,
  output logic                  busy,
  output logic                  timeout_err,
  input  logic                  clr_err
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [IDX_W-1:0]    gidx_q, gidx_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic                cmd_rd_q, cmd_rd_d;
  logic                cmd_wr_q, cmd_wr_d;
  logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;

  logic [NUM_REQ-1:0]  pick_onehot;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_valid;
  logic                set_err;
  logic                done;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req    (req_read | req_write),
    .last   (last_q),
    .onehot (pick_onehot),
    .index  (pick_idx),
    .valid  (pick_valid)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= ARB_IDLE;
      last_q      <= IDX_W'(NUM_REQ - 1);
      gidx_q      <= '0;
      grant_q     <= '0;
      cmd_rd_q    <= 1'b0;
      cmd_wr_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gidx_q      <= gidx_d;
      grant_q     <= grant_d;
      cmd_rd_q    <= cmd_rd_d;
      cmd_wr_q    <= cmd_wr_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    gidx_d       = gidx_q;
    grant_d      = grant_q;
    cmd_rd_d     = cmd_rd_q;
    cmd_wr_d     = cmd_wr_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_wdata_d  = cmd_wdata_q;
    cnt_d        = cnt_q;
    set_err      = 1'b0;
    done         = 1'b0;
    req_finished = '0;
    req_readdata = '0;

    case (state_q)
      ARB_IDLE: begin
        cnt_d = '0;
        if (pick_valid) begin
          state_d     = ARB_BUSY;
          gidx_d      = pick_idx;
          grant_d     = pick_onehot;
          // A simultaneous read+write is resolved as a write and flagged.
          cmd_wr_d    = req_write[pick_idx];
          cmd_rd_d    = req_read[pick_idx] & ~req_write[pick_idx];
          set_err     = req_read[pick_idx] & req_write[pick_idx];
          cmd_addr_d  = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
          cmd_wdata_d = req_writedata[int'(pick_idx)*DATA_W +: DATA_W];
        end
      end
      ARB_BUSY: begin
        // A real completion in the timeout cycle takes precedence over the forced one.
        done = sdram_finished || (cnt_q == CNT_W'(TIMEOUT));
        if (done) begin
          set_err      = ~sdram_finished;
          req_finished = grant_q;
          req_readdata = sdram_finished ? sdram_readdata : '0;
          state_d      = ARB_IDLE;
          last_d       = gidx_q;
          grant_d      = '0;
          cmd_rd_d     = 1'b0;
          cmd_wr_d     = 1'b0;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    // Set has priority over clear.
    err_d = (err_q & ~clr_err) | set_err;
  end

  assign busy            = (state_q == ARB_BUSY);
  assign grant           = grant_q;
  assign sdram_read      = cmd_rd_q;
  assign sdram_write     = cmd_wr_q;
  assign sdram_addr      = busy ? cmd_addr_q : '0;
  assign sdram_writedata = busy ? cmd_wdata_q : '0;
  assign timeout_err     = err_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - self-checking bench for sdram_arbiter
module tb_sdram_arbiter;

  localparam int NR = 4;
  localparam int AW = 23;
  localparam int DW = 32;
  localparam int TO = 255;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b0;
  logic [NR-1:0]     req_read = '0;
  logic [NR-1:0]     req_write = '0;
  logic [NR*AW-1:0]  req_addr = '0;
  logic [NR*DW-1:0]  req_writedata = '0;
  logic [DW-1:0]     req_readdata;
  logic [NR-1:0]     req_finished;
  logic              sdram_read;
  logic              sdram_write;
  logic [AW-1:0]     sdram_addr;
  logic [DW-1:0]     sdram_writedata;
  logic [DW-1:0]     sdram_readdata = '0;
  logic              sdram_finished = 1'b0;
  logic [NR-1:0]     grant;
  logic              busy;
  logic              timeout_err;
  logic              clr_err = 1'b0;

  sdram_arbiter #(
    .NUM_REQ (NR),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .req_read        (req_read),
    .req_write       (req_write),
    .req_addr        (req_addr),
    .req_writedata   (req_writedata),
    .req_readdata    (req_readdata),
    .req_finished    (req_finished),
    .sdram_read      (sdram_read),
    .sdram_write     (sdram_write),
    .sdram_addr      (sdram_addr),
    .sdram_writedata (sdram_writedata),
    .sdram_readdata  (sdram_readdata),
    .sdram_finished  (sdram_finished),
    .grant           (grant),
    .busy            (busy),
    .timeout_err     (timeout_err),
    .clr_err         (clr_err)
  );

  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          m;
    logic        rd;
    logic        wr;
    logic [22:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    logic        drop;
    logic        exp_rd;
    logic        exp_wr;
    logic        exp_err;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int m, input logic rd, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_read[m]             = rd;
    req_write[m]            = wr;
    req_addr[m*AW +: AW]    = a;
    req_writedata[m*DW +: DW] = d;
  endtask

  task automatic wait_busy(input string name);
    int c;
    c = 0;
    while (!busy && c < 20) begin
      @(negedge i_clk);
      c++;
    end
    chk(name, 64'(busy), 64'd1);
  endtask

  task automatic quick_read(input int m, input logic [AW-1:0] a);
    set_req(m, 1'b1, 1'b0, a, '0);
    wait_busy("quick_busy");
    chk("quick_grant", 64'(grant), 64'(4'b1 << m));
    sdram_finished = 1'b1;
    #1 chk("quick_fin", 64'(req_finished), 64'(4'b1 << m));
    @(negedge i_clk);
    sdram_finished = 1'b0;
    set_req(m, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    int order[6];
    int n;

    order = '{0, 1, 2, 0, 1, 2};
    vecs[0] = '{0, 1'b1, 1'b0, 23'h000010, 32'h0,        3, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{2, 1'b0, 1'b1, 23'h00ABCD, 32'h12345678, 4, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1, 1'b1, 1'b0, 23'h7FFFFF, 32'h0,        1, 32'hA5A5A5A5, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{3, 1'b1, 1'b1, 23'h000001, 32'hCAFEF00D, 2, 32'h5555AAAA, 1'b0, 1'b0, 1'b1, 1'b1};

    // Reset state
    repeat (3) @(negedge i_clk);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sdram_read", 64'(sdram_read), 64'd0);
    chk("rst_sdram_write", 64'(sdram_write), 64'd0);
    chk("rst_err", 64'(timeout_err), 64'd0);
    chk("rst_finished", 64'(req_finished), 64'd0);
    i_rst = 1'b1;
    @(negedge i_clk);

    // Round robin among masters 0,1,2 requesting continuously from reset
    req_read = 4'b0111;
    for (int i = 0; i < 6; i++) begin
      wait_busy("rr_busy");
      chk("rr_grant", 64'(grant), 64'(4'b1 << order[i]));
      chk("rr_sdram_read", 64'(sdram_read), 64'd1);
      sdram_finished = 1'b1;
      sdram_readdata = 32'h100 + 32'(i);
      #1;
      chk("rr_finished", 64'(req_finished), 64'(4'b1 << order[i]));
      chk("rr_readdata", 64'(req_readdata), 64'(32'h100 + 32'(i)));
      @(negedge i_clk);
      sdram_finished = 1'b0;
      sdram_readdata = '0;
      chk("rr_idle_gap", 64'(busy), 64'd0);
      if (i == 5) req_read = '0;
    end

    // Table-driven single-master accesses
    for (int v = 0; v < 4; v++) begin
      set_req(vecs[v].m, vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].wdata);
      wait_busy("vec_busy");
      chk("vec_grant", 64'(grant), 64'(4'b1 << vecs[v].m));
      for (int c = 1; c <= vecs[v].lat; c++) begin
        chk("vec_sdram_read", 64'(sdram_read), 64'(vecs[v].exp_rd));
        chk("vec_sdram_write", 64'(sdram_write), 64'(vecs[v].exp_wr));
        chk("vec_sdram_addr", 64'(sdram_addr), 64'(vecs[v].addr));
        chk("vec_sdram_wdata", 64'(sdram_writedata), 64'(vecs[v].wdata));
        if (vecs[v].drop && c == 1) set_req(vecs[v].m, 1'b0, 1'b0, '0, '0);
        if (c == vecs[v].lat) begin
          sdram_finished = 1'b1;
          sdram_readdata = vecs[v].rdata;
          #1;
          chk("vec_finished", 64'(req_finished), 64'(4'b1 << vecs[v].m));
          chk("vec_readdata", 64'(req_readdata), 64'(vecs[v].rdata));
        end else begin
          #1;
          chk("vec_no_finish", 64'(req_finished), 64'd0);
          chk("vec_readdata_zero", 64'(req_readdata), 64'd0);
        end
        @(negedge i_clk);
      end
      sdram_finished = 1'b0;
      sdram_readdata = '0;
      set_req(vecs[v].m, 1'b0, 1'b0, '0, '0);
      chk("vec_after_busy", 64'(busy), 64'd0);
      chk("vec_after_read", 64'(sdram_read), 64'd0);
      chk("vec_after_write", 64'(sdram_write), 64'd0);
      chk("vec_after_grant", 64'(grant), 64'd0);
      chk("vec_err", 64'(timeout_err), 64'(vecs[v].exp_err));
      if (vecs[v].exp_err) begin
        clr_err = 1'b1;
        @(negedge i_clk);
        clr_err = 1'b0;
        chk("vec_err_clr", 64'(timeout_err), 64'd0);
      end
    end

    // Timeout: master 1 read, SDRAM never finishes
    set_req(1, 1'b1, 1'b0, 23'h000100, '0);
    sdram_readdata = 32'h11111111;
    wait_busy("to_busy");
    n = 0;
    for (int c = 1; c <= 400; c++) begin
      if (req_finished != '0) begin
        n = c;
        break;
      end
      @(negedge i_clk);
    end
    chk("to_cycle", 64'(n), 64'(TO + 1));
    chk("to_finished", 64'(req_finished), 64'(4'b0010));
    chk("to_readdata", 64'(req_readdata), 64'd0);
    @(negedge i_clk);
    set_req(1, 1'b0, 1'b0, '0, '0);
    sdram_readdata = '0;
    chk("to_err_set", 64'(timeout_err), 64'd1);
    chk("to_idle", 64'(busy), 64'd0);
    repeat (3) @(negedge i_clk);
    chk("to_err_sticky", 64'(timeout_err), 64'd1);
    clr_err = 1'b1;
    @(negedge i_clk);
    clr_err = 1'b0;
    chk("to_err_clr", 64'(timeout_err), 64'd0);

    // Collision with clr_err in the same cycle: set wins
    set_req(3, 1'b1, 1'b1, 23'h000333, 32'h0BADCAFE);
    clr_err = 1'b1;
    @(negedge i_clk);
    clr_err = 1'b0;
    chk("col_busy", 64'(busy), 64'd1);
    chk("col_read", 64'(sdram_read), 64'd0);
    chk("col_write", 64'(sdram_write), 64'd1);
    chk("col_err_set_wins", 64'(timeout_err), 64'd1);
    sdram_finished = 1'b1;
    #1 chk("col_finished", 64'(req_finished), 64'(4'b1000));
    @(negedge i_clk);
    sdram_finished = 1'b0;
    set_req(3, 1'b0, 1'b0, '0, '0);
    clr_err = 1'b1;
    @(negedge i_clk);
    clr_err = 1'b0;
    chk("col_err_clr", 64'(timeout_err), 64'd0);

    // Reset during BUSY; last winner before it was master 0
    quick_read(0, 23'h000050);
    set_req(2, 1'b1, 1'b0, 23'h000200, '0);
    wait_busy("rst_mid_busy");
    chk("rst_mid_grant", 64'(grant), 64'(4'b0100));
    i_rst = 1'b0;
    #1;
    chk("rst_mid_read_drop", 64'(sdram_read), 64'd0);
    chk("rst_mid_busy_drop", 64'(busy), 64'd0);
    chk("rst_mid_grant_drop", 64'(grant), 64'd0);
    @(negedge i_clk);
    i_rst = 1'b1;
    set_req(2, 1'b0, 1'b0, '0, '0);
    sdram_finished = 1'b1;
    sdram_readdata = 32'hBAD0BAD0;
    #1;
    chk("stray_finished", 64'(req_finished), 64'd0);
    chk("stray_readdata", 64'(req_readdata), 64'd0);
    @(negedge i_clk);
    sdram_finished = 1'b0;
    sdram_readdata = '0;
    chk("stray_idle", 64'(busy), 64'd0);
    set_req(1, 1'b1, 1'b0, 23'h000111, '0);
    set_req(0, 1'b1, 1'b0, 23'h000222, '0);
    wait_busy("post_rst_busy");
    chk("post_rst_grant", 64'(grant), 64'(4'b0001));
    chk("post_rst_addr", 64'(sdram_addr), 64'(23'h000222));
    sdram_finished = 1'b1;
    #1 chk("post_rst_finished", 64'(req_finished), 64'(4'b0001));
    @(negedge i_clk);
    sdram_finished = 1'b0;
    req_read = '0;
    @(negedge i_clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
